// File: rtl/weight_buf_writer_if.sv
// Load-stream channel into the weight buffer: valid/ready handshake with data and end-of-image marker.
interface weight_buf_writer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/weight_buf_writer.sv
// Weight buffer loader: streams DATA_DEPTH words into a local array, checks framing
// against s_last, and exposes the image for reading only once a full load completes.
module weight_buf_writer #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DATA_DEPTH = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  weight_buf_writer_if.slave    load,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  loaded,
  output logic                  err
);

  // One extra pointer bit so the count can reach DATA_DEPTH without wrapping.
  localparam int unsigned PTR_WIDTH = $clog2(DATA_DEPTH + 1);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DATA_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic                  hs;
  logic                  rd_in_range;

  assign load.s_ready = (state == LOAD);
  assign busy         = (state == LOAD);
  assign hs           = load.s_valid & load.s_ready;

  // Control FSM: pointer, completion and framing-error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      loaded <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= LOAD;
            wr_ptr <= '0;
            loaded <= 1'b0;
            err    <= 1'b0;
          end
        end
        LOAD: begin
          if (hs) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (wr_ptr == LAST_PTR) begin
              state  <= DONE;
              loaded <= 1'b1;
              err    <= ~load.s_last;
            end else if (load.s_last) begin
              state  <= IDLE;
              loaded <= 1'b0;
              err    <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          wr_ptr <= '0;
          loaded <= 1'b0;
          err    <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately unreset; only accepted words overwrite it.
  always_ff @(posedge clk) begin
    if (hs) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= load.s_data;
    end
  end

  assign rd_in_range = (32'(rd_addr) < DATA_DEPTH);
  assign rd_data     = (loaded && rd_in_range) ? mem[rd_addr] : '0;

endmodule

// File: tb/tb_weight_buf_writer.sv
// Directed bench for weight_buf_writer: full loads, stalls, framing errors, reset abort, start-in-load.
module tb_weight_buf_writer;

  localparam int unsigned DW = 8;
  localparam int unsigned DD = 16;
  localparam int unsigned AW = $clog2(DD);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          loaded;
  logic          err;

  weight_buf_writer_if #(.DATA_WIDTH(DW)) load_if ();

  weight_buf_writer #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .load   (load_if),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy   (busy),
    .loaded (loaded),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int hs_cnt = 0;

  always @(posedge clk) begin
    if (load_if.s_valid && load_if.s_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one word; ready is sampled mid-cycle, then the edge is taken.
  task automatic send_word(input logic [DW-1:0] d, input logic last, input logic exp_ready,
                           input string tag);
    load_if.s_valid = 1'b1;
    load_if.s_data  = d;
    load_if.s_last  = last;
    @(negedge clk);
    check(tag, 32'(load_if.s_ready), 32'(exp_ready));
    tick();
    load_if.s_valid = 1'b0;
    load_if.s_last  = 1'b0;
  endtask

  task automatic check_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    rd_addr = a;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_flags(input logic eb, input logic el, input logic ee, input string tag);
    check({tag, ".busy"},   32'(busy),   32'(eb));
    check({tag, ".loaded"}, 32'(loaded), 32'(el));
    check({tag, ".err"},    32'(err),    32'(ee));
  endtask

  int hs0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    rd_addr = '0;
    load_if.s_valid = 1'b0;
    load_if.s_data  = '0;
    load_if.s_last  = 1'b0;

    // Reset state
    #12;
    check_flags(1'b0, 1'b0, 1'b0, "rst");
    check("rst.ready", 32'(load_if.s_ready), 32'd0);
    check_rd(4'd5, 8'h00, "rst.rd");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_flags(1'b0, 1'b0, 1'b0, "post_rst");

    // Continuous load 0x10..0x1F, loaded exactly after the 16th handshake
    pulse_start();
    check_flags(1'b1, 1'b0, 1'b0, "a.started");
    for (int i = 0; i < 16; i++) begin
      send_word(8'(8'h10 + i), (i == 15), 1'b1, "a.ready");
      if (i == 14) check("a.loaded_early", 32'(loaded), 32'd0);
    end
    check_flags(1'b0, 1'b1, 1'b0, "a.done");
    check_rd(4'd5,  8'h15, "a.rd5");
    check_rd(4'd0,  8'h10, "a.rd0");
    check_rd(4'd15, 8'h1F, "a.rd15");

    // Same image with s_valid toggling; ready must hold through gaps
    pulse_start();
    check("b.loaded_clr", 32'(loaded), 32'd0);
    hs0 = hs_cnt;
    for (int i = 0; i < 16; i++) begin
      send_word(8'(8'h10 + i), (i == 15), 1'b1, "b.ready");
      if (i != 15) begin
        @(negedge clk);
        check("b.gap_ready", 32'(load_if.s_ready), 32'd1);
        tick();
      end
    end
    check("b.writes", 32'(hs_cnt - hs0), 32'd16);
    check_flags(1'b0, 1'b1, 1'b0, "b.done");
    for (int a = 0; a < 16; a++) check_rd(AW'(a), 8'(8'h10 + a), "b.rd");

    // Early s_last on word 10 -> framing error, buffer unreadable
    pulse_start();
    for (int i = 0; i < 10; i++) send_word(8'(8'h40 + i), (i == 9), 1'b1, "c.ready");
    check_flags(1'b0, 1'b0, 1'b1, "c.short");
    for (int a = 0; a < 16; a++) check_rd(AW'(a), 8'h00, "c.rd_zero");
    send_word(8'h99, 1'b0, 1'b0, "c.idle_ready");
    check("c.idle_hs", 32'(busy), 32'd0);
    pulse_start();
    check_flags(1'b1, 1'b0, 1'b0, "c.restart");

    // 16 words without s_last -> loaded with err; 17th word refused
    for (int i = 0; i < 16; i++) send_word(8'(8'h60 + i), 1'b0, 1'b1, "d.ready");
    check_flags(1'b0, 1'b1, 1'b1, "d.nolast");
    hs0 = hs_cnt;
    send_word(8'hEE, 1'b1, 1'b0, "d.extra_ready");
    check("d.extra_hs", 32'(hs_cnt - hs0), 32'd0);
    check_rd(4'd0,  8'h60, "d.rd0");
    check_rd(4'd15, 8'h6F, "d.rd15");
    check_flags(1'b0, 1'b1, 1'b1, "d.hold");

    // Reset mid-load after 7 words, then full reload 0xA0..0xAF
    pulse_start();
    for (int i = 0; i < 7; i++) send_word(8'(8'h70 + i), 1'b0, 1'b1, "e.ready");
    rst_n = 1'b0;
    #1;
    check_flags(1'b0, 1'b0, 1'b0, "e.rst");
    check("e.rst_ready", 32'(load_if.s_ready), 32'd0);
    check_rd(4'd3, 8'h00, "e.rst_rd");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_flags(1'b0, 1'b0, 1'b0, "e.released");
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(8'(8'hA0 + i), (i == 15), 1'b1, "e.reload_ready");
    check_flags(1'b0, 1'b1, 1'b0, "e.done");
    check_rd(4'd3,  8'hA3, "e.rd3");
    check_rd(4'd10, 8'hAA, "e.rd10");

    // start during LOAD at word 4 must not restart the load
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) start = 1'b1;
      send_word(8'(8'hB0 + i), (i == 15), 1'b1, "f.ready");
      start = 1'b0;
      if (i == 3) check_flags(1'b1, 1'b0, 1'b0, "f.ignored");
    end
    check_flags(1'b0, 1'b1, 1'b0, "f.done");
    check_rd(4'd4,  8'hB4, "f.rd4");
    check_rd(4'd15, 8'hBF, "f.rd15");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
